// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
package mux_scan_pkg;

  localparam int unsigned MUX_SCAN_WIDTH = 16;
  localparam int unsigned MUX_SCAN_SEL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } mux_scan_state_e;

  // Highest select position for a word of the given width.
  function automatic int unsigned mux_scan_last_sel(input int unsigned width);
    return width - 1;
  endfunction

endpackage

// File: rtl/generate_mux.sv
// Plain WIDTH:1 combinational mux; the scan controller's partner stage.
module generate_mux
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_SCAN_WIDTH,
  parameter int unsigned SEL_W = MUX_SCAN_SEL_W
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0] select_i,
  output logic             out_o
);

  assign out_o = data_i[select_i];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives a word onto a 16:1 mux, steps select through every position,
// captures the mux output bit by bit and presents the rebuilt word.
// Optional feature: MUX_SCAN_PARITY_EN adds out_parity_o (XOR of captured bits).
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_SCAN_WIDTH,
  parameter int unsigned SEL_W = MUX_SCAN_SEL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic [WIDTH-1:0] mux_data_o,
  output logic [SEL_W-1:0] mux_select_o,
  input  logic             mux_out_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
`ifdef MUX_SCAN_PARITY_EN
  output logic             out_parity_o,
`endif
  output logic             busy_o
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SCAN = ST_SCAN;
  localparam logic [1:0] DONE = ST_DONE;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(mux_scan_last_sel(WIDTH));

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [SEL_W-1:0] sel_q,   sel_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             accept;

  // DONE may hand off straight to a new word when downstream takes the result.
  assign in_ready_o = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // Next-state: scan step, termination before increment, accept overrides.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    res_d   = res_q;
    case (state_q)
      SCAN: begin
        res_d[sel_q] = mux_out_i;
        if (sel_q == LAST_SEL) state_d = DONE;
        else                   sel_d   = sel_q + 1'b1;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      data_d  = in_data_i;
      sel_d   = '0;
      res_d   = '0;
      state_d = SCAN;
    end
  end

  // State, mux drive and result registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
    end
  end

  assign mux_data_o   = data_q;
  assign mux_select_o = sel_q;
  assign out_valid_o  = (state_q == DONE);
  assign out_data_o   = res_q;
  assign busy_o       = (state_q == SCAN);

`ifdef MUX_SCAN_PARITY_EN
  logic par_q, par_d;

  // Running XOR of captured bits, restarted on every accept.
  always_comb begin
    par_d = par_q;
    if (state_q == SCAN) par_d = par_q ^ mux_out_i;
    if (accept)          par_d = 1'b0;
  end

  // Parity register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign out_parity_o = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl paired with generate_mux.
// Honours MUX_SCAN_PARITY_EN to also check out_parity_o.
module tb_mux_scan_ctrl;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] mux_data;
  logic [S-1:0] mux_select;
  logic         mux_out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         busy;
`ifdef MUX_SCAN_PARITY_EN
  logic         out_parity;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.WIDTH(W), .SEL_W(S)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .mux_data_o(mux_data), .mux_select_o(mux_select), .mux_out_i(mux_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
`ifdef MUX_SCAN_PARITY_EN
    .out_parity_o(out_parity),
`endif
    .busy_o(busy)
  );

  generate_mux #(.WIDTH(W), .SEL_W(S)) u_mux (
    .data_i(mux_data), .select_i(mux_select), .out_o(mux_out)
  );

  typedef struct {
    string      name;
    logic [15:0] din;
    logic [15:0] exp_out;
    logic        exp_par;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_par(input string name, input logic exp);
`ifdef MUX_SCAN_PARITY_EN
    chk(name, {31'd0, out_parity}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unused parity %s", name);
`endif
  endtask

  // Wait (bounded) for in_ready, then present a word for one accept edge.
  // Returns just after the accept edge with in_valid dropped unless keep_valid.
  task automatic accept_word(input string name, input logic [15:0] d, input bit keep_valid);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // From just after accept edge N, step to N+16 checking select walk.
  task automatic scan_to_done(input string name);
    bit sel_ok = 1'b1;
    bit early  = 1'b0;
    chk({name, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < 15; k++) begin
      if (mux_select !== S'(k)) sel_ok = 1'b0;
      if (out_valid) early = 1'b1;
      tick();
    end
    if (mux_select !== S'(15)) sel_ok = 1'b0;
    if (out_valid) early = 1'b1;
    chk({name, "_sel_walk"}, {31'd0, sel_ok}, 32'd1);
    chk({name, "_no_early_valid"}, {31'd0, early}, 32'd0);
    tick();
    chk({name, "_valid_at_16"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_sel_held"}, {28'd0, mux_select}, 32'd15);
  endtask

  initial begin
    vecs[0] = '{"basic",  16'hA3F1, 16'hA3F1, 1'b1};
    vecs[1] = '{"zero",   16'h0000, 16'h0000, 1'b0};
    vecs[2] = '{"ends",   16'h8001, 16'h8001, 1'b0};
    vecs[3] = '{"ones",   16'hFFFF, 16'hFFFF, 1'b0};
    vecs[4] = '{"single", 16'h0001, 16'h0001, 1'b1};
    vecs[5] = '{"mixed",  16'h1234, 16'h1234, 1'b1};

    // Reset state
    #12;
    chk("rst_mux_data", {16'd0, mux_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sel", {28'd0, mux_select}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);

    // Table-driven scans with out_ready held high
    for (int i = 0; i < 6; i++) begin
      accept_word(vecs[i].name, vecs[i].din, 1'b0);
      chk({vecs[i].name, "_mux_data"}, {16'd0, mux_data}, {16'd0, vecs[i].din});
      scan_to_done(vecs[i].name);
      chk({vecs[i].name, "_out_data"}, {16'd0, out_data}, {16'd0, vecs[i].exp_out});
      chk_par({vecs[i].name, "_par"}, vecs[i].exp_par);
      tick();
      chk({vecs[i].name, "_idle_after"}, {31'd0, out_valid}, 32'd0);
      chk({vecs[i].name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: result held, no new accept
    out_ready = 1'b0;
    accept_word("bp", 16'h5A5A, 1'b0);
    scan_to_done("bp");
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_held_data", {16'd0, out_data}, 32'h5A5A);
      chk("bp_held_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    chk("bp_no_accept", {16'd0, mux_data}, 32'h5A5A);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_idle", {30'd0, out_valid, busy}, 32'd0);
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back: second accept on the first output handshake
    accept_word("b2b_a", 16'hFFFF, 1'b1);
    in_data = 16'h0001;
    scan_to_done("b2b_a");
    chk("b2b_a_data", {16'd0, out_data}, 32'hFFFF);
    chk("b2b_bypass_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_second_accept", {31'd0, busy}, 32'd1);
    chk("b2b_second_mux_data", {16'd0, mux_data}, 32'h0001);
    scan_to_done("b2b_b");
    chk("b2b_b_data", {16'd0, out_data}, 32'h0001);
    tick();

    // in_valid pulse mid-scan is ignored
    accept_word("ign", 16'hC3A5, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    chk("ign_at_step7", {28'd0, mux_select}, 32'd7);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk("ign_mux_data", {16'd0, mux_data}, 32'hC3A5);
    for (int k = 0; k < 8; k++) tick();
    chk("ign_valid", {31'd0, out_valid}, 32'd1);
    chk("ign_out_data", {16'd0, out_data}, 32'hC3A5);
    tick();

    // Mid-scan asynchronous reset at step 9
    accept_word("mrst", 16'hBEEF, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    chk("mrst_at_step9", {28'd0, mux_select}, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mrst_mux_data", {16'd0, mux_data}, 32'd0);
    chk("mrst_sel", {28'd0, mux_select}, 32'd0);
    chk("mrst_out_data", {16'd0, out_data}, 32'd0);
    chk("mrst_flags", {30'd0, out_valid, busy}, 32'd0);
    chk_par("mrst_par", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_ready", {31'd0, in_ready}, 32'd1);
    accept_word("post", 16'h8001, 1'b0);
    scan_to_done("post");
    chk("post_out_data", {16'd0, out_data}, 32'h8001);
    chk_par("post_par", 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
